motor_speed_meter: RTL and testbench
====================================

Name: motor_speed_meter

Overview:
- Motor-side producer of the speed-feedback interface consumed by the motor speed controller.
- Decodes a filtered quadrature encoder (A/B plus index) into a signed position count.
- Counts signed encoder steps over a fixed gate window and presents the total on motor_speed with a one-cycle new_motor_speed strobe.
- Sits between the encoder input pins and the controller's motor_speed / new_motor_speed inputs.

Parameters:
- GATE_CYCLES, 100000: ce-qualified clock cycles per measurement window (1 ms at 100 MHz); minimum 2.
- FILT_LEN, 4: consecutive ce cycles a synchronized input must hold a new level before it is accepted; minimum 1.

Ports:
- clk  in  1  system clock; everything is synchronous to it.
- rstn  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; filter, decoder and gate logic advance only when high.
- enc_a  in  1  encoder channel A, asynchronous.
- enc_b  in  1  encoder channel B, asynchronous.
- enc_i  in  1  encoder index, asynchronous.
- err_clr  in  1  clears enc_err.
- motor_speed  out  32  signed steps counted in the last completed window.
- new_motor_speed  out  1  one-cycle strobe; motor_speed is updated in the same cycle.
- position  out  32  signed accumulated position.
- dir  out  1  direction of the last valid step: 1 = forward, 0 = reverse.
- enc_err  out  1  sticky flag for an illegal quadrature transition.

Behaviour:
- Reset: all outputs, counters, filter state and the accumulator go to 0; the filtered A/B/I levels also reset to 0.
- Synchronizer: 2 flops per input, always clocked (not gated by ce).
- Glitch filter, per channel:
  - A counter increments while the synchronized value differs from the filtered value and ce=1.
  - When the counter reaches FILT_LEN, the filtered value takes the new level and the counter clears.
  - Any return to agreement clears the counter.
- Latency from a pin edge to the filtered edge: 2 + FILT_LEN ce cycles. The step is applied in the following cycle.
- Decoder: compares the previous filtered {A,B} with the current filtered {A,B}.
  - Forward sequence 00→01→11→10→00: step +1, dir<=1.
  - Reverse sequence: step −1, dir<=0.
  - No change: step 0.
  - Both bits changed: step 0, enc_err<=1.
- enc_err: err_clr clears it. If an illegal transition and err_clr occur in the same cycle, the set wins.
- position: position += step, with two's-complement wrap (0x7FFFFFFF + 1 → 0x80000000).
  - A rising edge on the filtered index forces position<=0.
  - Index has priority over a step in the same cycle.
- Gate counter: runs 0..GATE_CYCLES−1 on ce cycles. At terminal count:
  - motor_speed <= acc + step (the current-cycle step is included).
  - acc <= 0.
  - new_motor_speed=1 for exactly one clk.
- acc between windows: acc += step, saturating at +0x7FFFFFFF and −0x80000000. No wrap.
- ce=0: filter counters, decoder, acc and the gate counter all hold. new_motor_speed=0. Outputs are stable.
- Reset asserted mid-window: the partial count is discarded. The first strobe after release comes GATE_CYCLES ce cycles later.

Optional Feature:
- Macro: MOTOR_SPEED_AVG_EN
- Defined: motor_speed = arithmetic-shift-right-by-2 of the 34-bit sum of the last 4 window results, truncated to 32 bits.
  - The history registers reset to 0, so the first three strobes average in zeros.
  - The strobe timing is unchanged.
- Undefined: motor_speed is the raw window count. No history registers are built.

Decomposition:
- Package motor_speed_pkg holds:
  - The quadrature phase typedef (2-bit, enumerated 00/01/11/10).
  - The step typedef (signed 2-bit: −1/0/+1).
  - The 32-bit speed width constant.
  - The saturation limit constants.
- One sub-module, motor_enc_filter: the 2-flop synchronizer plus glitch filter for a single bit, parameterized by FILT_LEN, instantiated 3×.

Test Plan (GATE_CYCLES=100, FILT_LEN=4, ce=1 unless noted):
- 10 forward steps in window 1 (pin edges ≥8 cycles apart) → strobe at cycle 100 with motor_speed=10, position=10, dir=1; the next window with no motion gives motor_speed=0.
- 7 reverse steps from position=0 → motor_speed=0xFFFFFFF9, position=−7, dir=0.
- 3-cycle pulse on enc_a → no filtered edge, position unchanged; a 4-cycle pulse → +1 then −1 step.
- A and B toggled in the same cycle → enc_err=1 and position unchanged; err_clr → enc_err=0.
- Index rising edge coincident with a forward step at position=55 → position=0; ce held low for 50 cycles mid-window → strobe delayed by 50 cycles.
- MOTOR_SPEED_AVG_EN with raw windows 8, 8, 8, 8 → strobes 2, 4, 6, 8; rstn pulsed mid-window → all outputs 0, next strobe 100 cycles after release.

Source files
------------

// File: rtl/motor_speed_pkg.sv
// Shared types and constants for the motor speed meter: quadrature phases,
// signed step encoding, speed width and the saturating accumulator helper.
package motor_speed_pkg;

    localparam int SPEED_W = 32;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_t;

    typedef logic signed [1:0] step_t;

    localparam step_t STEP_NONE = 2'sd0;
    localparam step_t STEP_FWD  = 2'sd1;
    localparam step_t STEP_REV  = -2'sd1;

    localparam logic signed [SPEED_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [SPEED_W-1:0] SAT_MIN = 32'sh8000_0000;

    // Successor of a phase in the forward direction (00 -> 01 -> 11 -> 10 -> 00).
    function automatic phase_t next_fwd(input phase_t p);
        case (p)
            PH_00:   return PH_01;
            PH_01:   return PH_11;
            PH_11:   return PH_10;
            default: return PH_00;
        endcase
    endfunction

    function automatic logic signed [SPEED_W-1:0] sat_add(
        input logic signed [SPEED_W-1:0] a,
        input step_t                     s
    );
        logic signed [SPEED_W:0] sum;
        sum = (SPEED_W+1)'(a) + (SPEED_W+1)'(s);
        if (sum > (SPEED_W+1)'(SAT_MAX))
            return SAT_MAX;
        else if (sum < (SPEED_W+1)'(SAT_MIN))
            return SAT_MIN;
        else
            return SPEED_W'(sum);
    endfunction

endpackage

// File: rtl/motor_enc_filter.sv
// Two-flop synchronizer plus glitch filter for one asynchronous encoder bit;
// a new level is accepted after FILT_LEN consecutive disagreeing ce cycles.
module motor_enc_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic ce,
    input  logic raw,
    output logic level
);
    localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // NOTE: all state here uses <= so each flop samples the pre-edge value of its source.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (ce) begin
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/motor_speed_meter.sv
// Quadrature decoder, position counter and gated speed measurement.
// Define MOTOR_SPEED_AVG_EN to report a 4-window moving average instead of the raw count.
module motor_speed_meter
    import motor_speed_pkg::*;
#(
    parameter int GATE_CYCLES = 100000,
    parameter int FILT_LEN    = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      ce,
    input  logic                      enc_a,
    input  logic                      enc_b,
    input  logic                      enc_i,
    input  logic                      err_clr,
    output logic signed [SPEED_W-1:0] motor_speed,
    output logic                      new_motor_speed,
    output logic signed [SPEED_W-1:0] position,
    output logic                      dir,
    output logic                      enc_err
);
    localparam int GW = (GATE_CYCLES < 2) ? 1 : $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    logic                      filt_a;
    logic                      filt_b;
    logic                      filt_i;
    phase_t                    prev_ab;
    phase_t                    cur_ab;
    logic                      prev_i;
    logic                      idx_rise;
    logic                      illegal;
    logic                      gate_end;
    step_t                     step;
    logic [GW-1:0]             gate_cnt;
    logic signed [SPEED_W-1:0] acc;
    logic signed [SPEED_W-1:0] acc_next;
    logic signed [SPEED_W-1:0] speed_next;

    motor_enc_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(clk), .rstn(rstn), .ce(ce), .raw(enc_a), .level(filt_a)
    );
    motor_enc_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(clk), .rstn(rstn), .ce(ce), .raw(enc_b), .level(filt_b)
    );
    motor_enc_filter #(.FILT_LEN(FILT_LEN)) u_filt_i (
        .clk(clk), .rstn(rstn), .ce(ce), .raw(enc_i), .level(filt_i)
    );

    assign cur_ab   = phase_t'({filt_a, filt_b});
    assign idx_rise = filt_i & ~prev_i;
    assign gate_end = (gate_cnt == GATE_LAST);
    assign acc_next = sat_add(acc, step);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        step    = STEP_NONE;
        illegal = 1'b0;
        if (cur_ab != prev_ab) begin
            if (cur_ab == next_fwd(prev_ab))
                step = STEP_FWD;
            else if (prev_ab == next_fwd(cur_ab))
                step = STEP_REV;
            else
                illegal = 1'b1;
        end
    end

`ifdef MOTOR_SPEED_AVG_EN
    logic signed [SPEED_W-1:0] hist0;
    logic signed [SPEED_W-1:0] hist1;
    logic signed [SPEED_W-1:0] hist2;
    logic signed [SPEED_W+1:0] hist_sum;

    assign hist_sum   = (SPEED_W+2)'(acc_next) + (SPEED_W+2)'(hist0)
                      + (SPEED_W+2)'(hist1) + (SPEED_W+2)'(hist2);
    assign speed_next = SPEED_W'(hist_sum >>> 2);

    // NOTE: the history is only three words, so it is reset like ordinary flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist0 <= '0;
            hist1 <= '0;
            hist2 <= '0;
        end else if (ce && gate_end) begin
            hist0 <= acc_next;
            hist1 <= hist0;
            hist2 <= hist1;
        end
    end
`else
    assign speed_next = acc_next;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_ab         <= PH_00;
            prev_i          <= 1'b0;
            position        <= '0;
            dir             <= 1'b0;
            enc_err         <= 1'b0;
            gate_cnt        <= '0;
            acc             <= '0;
            motor_speed     <= '0;
            new_motor_speed <= 1'b0;
        end else begin
            new_motor_speed <= 1'b0;
            if (ce) begin
                prev_ab <= cur_ab;
                prev_i  <= filt_i;
                // Index wins over a coincident step; position wraps, acc saturates.
                if (idx_rise)
                    position <= '0;
                else
                    position <= position + SPEED_W'(step);
                if (step == STEP_FWD)
                    dir <= 1'b1;
                else if (step == STEP_REV)
                    dir <= 1'b0;
                if (gate_end) begin
                    gate_cnt        <= '0;
                    acc             <= '0;
                    motor_speed     <= speed_next;
                    new_motor_speed <= 1'b1;
                end else begin
                    gate_cnt <= gate_cnt + GW'(1);
                    acc      <= acc_next;
                end
            end
            if (ce && illegal)
                enc_err <= 1'b1;
            else if (err_clr)
                enc_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_motor_speed_meter.sv
// Scoreboard bench for motor_speed_meter (GATE_CYCLES=100, FILT_LEN=4): window
// expectations are queued when stimulus starts and checked by a strobe monitor.
module tb_motor_speed_meter;

    typedef struct {
        logic [31:0] speed;
        logic [31:0] pos;
        logic        dir;
        int          cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn;
    logic               ce;
    logic               enc_a;
    logic               enc_b;
    logic               enc_i;
    logic               err_clr;
    logic signed [31:0] motor_speed;
    logic               new_motor_speed;
    logic signed [31:0] position;
    logic               dir;
    logic               enc_err;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];
    int   h0 = 0;
    int   h1 = 0;
    int   h2 = 0;

    motor_speed_meter #(.GATE_CYCLES(100), .FILT_LEN(4)) dut (
        .clk(clk), .rstn(rstn), .ce(ce),
        .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i), .err_clr(err_clr),
        .motor_speed(motor_speed), .new_motor_speed(new_motor_speed),
        .position(position), .dir(dir), .enc_err(enc_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_speed(input int raw);
`ifdef MOTOR_SPEED_AVG_EN
        longint sum;
        sum = longint'(raw) + longint'(h0) + longint'(h1) + longint'(h2);
        h2 = h1;
        h1 = h0;
        h0 = raw;
        return 32'(sum >>> 2);
`else
        return 32'(raw);
`endif
    endfunction

    task automatic push(input int raw, input int pos, input logic d, input int c);
        exp_t e;
        e.speed = model_speed(raw);
        e.pos   = 32'(pos);
        e.dir   = d;
        e.cyc   = c;
        q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic fwd();
        if (enc_a == enc_b) enc_b = ~enc_b;
        else                enc_a = ~enc_a;
    endtask

    task automatic rev();
        if (enc_a == enc_b) enc_a = ~enc_a;
        else                enc_b = ~enc_b;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn === 1'b1 && new_motor_speed === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_strobe: got strobe at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                check("motor_speed", motor_speed, e.speed);
                check("strobe_position", position, e.pos);
                check("strobe_dir", {31'b0, dir}, {31'b0, e.dir});
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int w_raw[5];
        int w_pos[5];
        w_raw = '{12, 13, 12, 13, 12};
        w_pos = '{5, 18, 30, 43, 55};

        rstn = 1'b0; ce = 1'b1; err_clr = 1'b0;
        enc_a = 1'b0; enc_b = 1'b0; enc_i = 1'b0;
        wait_cycles(3);
        check("reset_speed", motor_speed, 32'd0);
        check("reset_position", position, 32'd0);
        check("reset_strobe", {31'b0, new_motor_speed}, 32'd0);
        check("reset_err", {31'b0, enc_err}, 32'd0);
        rstn = 1'b1;
        w = cyc;

        // Window 1: ten forward steps.
        push(10, 10, 1'b1, w + 100);
        repeat (10) begin fwd(); wait_cycles(8); end
        wait_until(w + 100); w += 100;

        // Window 2: no motion.
        push(0, 10, 1'b1, w + 100);
        wait_until(w + 100); w += 100;

        // Window 3: index pulse zeroes position, then seven reverse steps.
        push(-7, -7, 1'b0, w + 100);
        enc_i = 1'b1; wait_cycles(8);
        enc_i = 1'b0; wait_cycles(8);
        check("index_zero", position, 32'd0);
        repeat (7) begin rev(); wait_cycles(8); end
        wait_until(w + 100); w += 100;

        // Window 4: glitch filter, illegal transition and error clear.
        push(0, -7, 1'b0, w + 100);
        enc_a = ~enc_a; wait_cycles(3);
        enc_a = ~enc_a; wait_cycles(9);
        check("glitch3_position", position, -32'sd7);
        enc_a = ~enc_a; wait_cycles(4);
        enc_a = ~enc_a; wait_cycles(4);
        check("pulse4_fwd_position", position, -32'sd6);
        check("pulse4_fwd_dir", {31'b0, dir}, 32'd1);
        wait_cycles(4);
        check("pulse4_rev_position", position, -32'sd7);
        check("pulse4_rev_dir", {31'b0, dir}, 32'd0);
        wait_cycles(2);
        enc_a = ~enc_a; enc_b = ~enc_b; wait_cycles(10);
        check("illegal_err", {31'b0, enc_err}, 32'd1);
        check("illegal_position", position, -32'sd7);
        err_clr = 1'b1; wait_cycles(1);
        err_clr = 1'b0; wait_cycles(1);
        check("err_cleared", {31'b0, enc_err}, 32'd0);
        wait_until(w + 100); w += 100;

        // Windows 5-9: 62 forward steps spread across five windows, ending at 55.
        for (int k = 0; k < 5; k++) push(w_raw[k], w_pos[k], 1'b1, w + 100 * (k + 1));
        repeat (62) begin fwd(); wait_cycles(8); end
        wait_until(w + 500); w += 500;

        // Window 10: index coincident with a forward step, then ce low for 50 cycles.
        push(1, 0, 1'b1, w + 150);
        enc_i = 1'b1; fwd(); wait_cycles(8);
        enc_i = 1'b0; wait_cycles(2);
        check("index_over_step", position, 32'd0);
        wait_until(w + 20);
        ce = 1'b0; wait_cycles(50);
        check("ce_hold_position", position, 32'd0);
        ce = 1'b1;
        wait_until(w + 150); w += 150;

        // Window 11: one step, then reset mid-window discards the partial count.
        wait_until(w + 30);
        fwd(); wait_cycles(10);
        check("pre_reset_position", position, 32'd1);
        wait_until(w + 50);
        rstn = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enc_i = 1'b0;
        h0 = 0; h1 = 0; h2 = 0;
        wait_cycles(1);
        check("midreset_speed", motor_speed, 32'd0);
        check("midreset_position", position, 32'd0);
        check("midreset_dir", {31'b0, dir}, 32'd0);
        check("midreset_strobe", {31'b0, new_motor_speed}, 32'd0);
        wait_cycles(1);
        rstn = 1'b1;
        w = cyc;
        push(1, 1, 1'b1, w + 100);
        fwd(); wait_cycles(8);
        wait_until(w + 100);

        wait_cycles(5);
        check("pending_strobes", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
